// File: rtl/divmult_sequencer.sv
// Iterative 16-step shift-add multiplier / restoring divider for the LC-3b execute stage.
// Stalls EX while running and holds its result until the pipeline advances.

package lc3b_types;
  typedef enum logic [3:0] {
    alu_add  = 4'd0,
    alu_and  = 4'd1,
    alu_not  = 4'd2,
    alu_pass = 4'd3,
    alu_sll  = 4'd4,
    alu_srl  = 4'd5,
    alu_sra  = 4'd6,
    alu_mult = 4'd7,
    alu_div  = 4'd8
  } lc3b_aluop;
endpackage

module divmult_sequencer
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  lc3b_aluop        aluop,
  input  logic [WIDTH-1:0] sr1,
  input  logic [WIDTH-1:0] sr2,
  input  logic             flow,
  output logic [WIDTH-1:0] solution,
  output logic             stall_X,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Unsigned magnitude of a two's complement value; the most negative value maps onto itself.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    magnitude = v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic [1:0]       state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] op_a_r;      // multiplicand (shifts left) or dividend→quotient
  logic [WIDTH-1:0] op_b_r;      // multiplier (shifts right) or divisor
  logic [WIDTH:0]   acc_r;       // product or partial remainder
  logic             sign_r;
  logic             is_div_r;
  logic             div_zero_r;
  logic [WIDTH-1:0] solution_r;
  logic             done_r;

  logic             start_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   acc_nxt_s;
  logic [WIDTH-1:0] op_a_nxt_s;
  logic [WIDTH-1:0] op_b_nxt_s;
  logic [WIDTH-1:0] mag_s;
  logic [WIDTH-1:0] result_s;

  assign start_s = (aluop == alu_mult) || (aluop == alu_div);

  // One iteration of the datapath plus the sign/zero fixup used on the final step.
  always_comb begin
    shifted_s  = {acc_r[WIDTH-1:0], op_a_r[WIDTH-1]};
    acc_nxt_s  = acc_r;
    op_a_nxt_s = op_a_r;
    op_b_nxt_s = op_b_r;
    if (is_div_r) begin
      op_b_nxt_s = op_b_r;
      if (shifted_s >= {1'b0, op_b_r}) begin
        acc_nxt_s  = shifted_s - {1'b0, op_b_r};
        op_a_nxt_s = {op_a_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt_s  = shifted_s;
        op_a_nxt_s = {op_a_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      op_a_nxt_s = {op_a_r[WIDTH-2:0], 1'b0};
      op_b_nxt_s = {1'b0, op_b_r[WIDTH-1:1]};
      if (op_b_r[0]) begin
        acc_nxt_s = acc_r + {1'b0, op_a_r};
      end else begin
        acc_nxt_s = acc_r;
      end
    end

    mag_s = is_div_r ? op_a_nxt_s : acc_nxt_s[WIDTH-1:0];
    if (is_div_r && div_zero_r) begin
      result_s = {WIDTH{1'b1}};
    end else if (sign_r) begin
      result_s = negate(mag_s);
    end else begin
      result_s = mag_s;
    end
  end

  // Sequencer state, operand latches and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      count_r    <= {CW{1'b0}};
      op_a_r     <= {WIDTH{1'b0}};
      op_b_r     <= {WIDTH{1'b0}};
      acc_r      <= {(WIDTH+1){1'b0}};
      sign_r     <= 1'b0;
      is_div_r   <= 1'b0;
      div_zero_r <= 1'b0;
      solution_r <= {WIDTH{1'b0}};
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_s) begin
            op_a_r     <= magnitude(sr1);
            op_b_r     <= magnitude(sr2);
            sign_r     <= sr1[WIDTH-1] ^ sr2[WIDTH-1];
            is_div_r   <= (aluop == alu_div);
            div_zero_r <= (sr2 == {WIDTH{1'b0}});
            acc_r      <= {(WIDTH+1){1'b0}};
            count_r    <= {CW{1'b0}};
            state_r    <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r   <= acc_nxt_s;
          op_a_r  <= op_a_nxt_s;
          op_b_r  <= op_b_nxt_s;
          count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
          if (count_r == LAST_ITER) begin
            solution_r <= result_s;
            done_r     <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (flow) begin
            done_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // The start cycle must stall before the FSM has left IDLE, hence combinational.
  assign stall_X  = ((state_r == ST_IDLE) && start_s) || (state_r == ST_RUN);
  assign solution = solution_r;
  assign done     = done_r;

endmodule

// File: tb/tb_divmult_sequencer.sv
// Randomized self-checking bench for divmult_sequencer against an integer-arithmetic model.
module tb_divmult_sequencer;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  lc3b_aluop   aluop = alu_add;
  logic [15:0] sr1 = 16'h0000;
  logic [15:0] sr2 = 16'h0000;
  logic        flow = 1'b0;
  logic [15:0] solution;
  logic        stall_X;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  divmult_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .aluop(aluop), .sr1(sr1), .sr2(sr2),
    .flow(flow), .solution(solution), .stall_X(stall_X), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: signed product truncated, or sign-fixed quotient of magnitudes.
  function automatic logic [15:0] ref_result(input bit is_div, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, ma, mb, q;
    sa = $signed(a);
    sb = $signed(b);
    if (!is_div) return 16'(sa * sb);
    if (b == 16'h0000) return 16'hFFFF;
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    q = ma / mb;
    if ((sa < 0) != (sb < 0)) q = -q;
    return 16'(q);
  endfunction

  // Issue one op, scramble inputs during RUN, return stall length and the DONE-cycle outputs.
  task automatic do_op(input lc3b_aluop op, input logic [15:0] a, input logic [15:0] b,
                       input bit release_flow,
                       output int stalls, output logic [15:0] sol, output logic dn);
    @(negedge clk);
    aluop = op; sr1 = a; sr2 = b; flow = 1'b0;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (stall_X) stalls++;
      else break;
      @(posedge clk);
      #1;
      aluop = alu_add; sr1 = 16'($urandom); sr2 = 16'($urandom); flow = 1'($urandom);
      @(negedge clk);
    end
    sol = solution;
    dn = done;
    flow = release_flow;
  endtask

  task automatic check_op(input string name, input bit is_div, input logic [15:0] a, input logic [15:0] b);
    int st;
    logic [15:0] sol, exp_sol;
    logic dn;
    exp_sol = ref_result(is_div, a, b);
    do_op(is_div ? alu_div : alu_mult, a, b, 1'b1, st, sol, dn);
    tests_run++;
    if (st !== 17) begin
      tests_failed++;
      $display("FAIL %s stall: got %0d cycles, expected 17", name, st);
    end
    tests_run++;
    if (sol !== exp_sol || dn !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s result: got %h done=%b, expected %h done=1 (a=%h b=%h)", name, sol, dn, exp_sol, a, b);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    aluop = alu_add;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (solution !== 16'h0000 || done !== 1'b0 || stall_X !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: got sol=%h done=%b stall=%b, expected 0000/0/0", solution, done, stall_X);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult;
    int st;
    logic [15:0] sol;
    logic dn;
    do_op(alu_mult, 16'd3, 16'd5, 1'b0, st, sol, dn);
    tests_run++;
    if (st !== 17 || sol !== 16'h000F || dn !== 1'b1) begin
      tests_failed++;
      $display("FAIL mult_3x5: got stall=%0d sol=%h done=%b, expected 17/000f/1", st, sol, dn);
    end
    flow = 1'b1;
    @(posedge clk); #1;
    flow = 1'b0;
    tests_run++;
    if (done !== 1'b0 || stall_X !== 1'b0 || solution !== 16'h000F) begin
      tests_failed++;
      $display("FAIL mult_flow_idle: got done=%b stall=%b sol=%h, expected 0/0/000f", done, stall_X, solution);
    end
    check_op("mult_neg", 1'b0, 16'hFFF9, 16'h0003);
    check_op("mult_trunc", 1'b0, 16'h0100, 16'h0100);
    check_op("mult_min", 1'b0, 16'h8000, 16'h0001);
  endtask

  task automatic test_div;
    check_op("div_100_7", 1'b1, 16'd100, 16'd7);
    check_op("div_neg", 1'b1, 16'hFF9C, 16'h0007);
    check_op("div_ovf", 1'b1, 16'h8000, 16'hFFFF);
  endtask

  task automatic test_div_zero;
    check_op("divz_pos", 1'b1, 16'h1234, 16'h0000);
    check_op("divz_neg", 1'b1, 16'hFFFF, 16'h0000);
  endtask

  task automatic test_hold;
    int st;
    logic [15:0] sol, exp_sol;
    logic dn;
    exp_sol = ref_result(1'b0, 16'h0123, 16'hFFF0);
    do_op(alu_mult, 16'h0123, 16'hFFF0, 1'b0, st, sol, dn);
    for (int i = 0; i < 5; i++) begin
      aluop = alu_mult; sr1 = 16'($urandom); sr2 = 16'($urandom);
      @(posedge clk); #1;
      tests_run++;
      if (solution !== exp_sol || stall_X !== 1'b0 || done !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold[%0d]: got sol=%h stall=%b done=%b, expected %h/0/1", i, solution, stall_X, done, exp_sol);
      end
    end
    aluop = alu_add;
    flow = 1'b1;
    @(posedge clk); #1;
    flow = 1'b0;
    tests_run++;
    if (done !== 1'b0 || stall_X !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_release: got done=%b stall=%b, expected 0/0", done, stall_X);
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    aluop = alu_mult; sr1 = 16'h1111; sr2 = 16'h2222;
    @(posedge clk); #1;
    aluop = alu_add;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (solution !== 16'h0000 || done !== 1'b0 || stall_X !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: got sol=%h done=%b stall=%b, expected 0000/0/0", solution, done, stall_X);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_op("after_reset_7x6", 1'b0, 16'd7, 16'd6);
  endtask

  task automatic test_non_muldiv;
    lc3b_aluop ops[7] = '{alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      aluop = ops[i]; sr1 = 16'($urandom); sr2 = 16'($urandom);
      #1;
      tests_run++;
      if (stall_X !== 1'b0) begin
        tests_failed++;
        $display("FAIL non_muldiv_stall[%0d]: got %b, expected 0", i, stall_X);
      end
      @(posedge clk); #1;
      tests_run++;
      if (done !== 1'b0 || stall_X !== 1'b0) begin
        tests_failed++;
        $display("FAIL non_muldiv_idle[%0d]: got done=%b stall=%b, expected 0/0", i, done, stall_X);
      end
    end
    aluop = alu_add;
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, b;
    bit is_div;
    for (int i = 0; i < 40; i++) begin
      is_div = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 5))
        0: b = 16'h0000;
        1: a = 16'h8000;
        2: b = 16'($urandom_range(1, 20));
        default: ;
      endcase
      check_op(is_div ? "rand_div" : "rand_mult", is_div, a, b);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_hold;
    test_reset_mid_run;
    test_non_muldiv;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/divmult_sequencer.md
# divmult_sequencer

Iterative multi-cycle multiply/divide engine for the execute stage. Accepts `alu_mult`/`alu_div` operations from the EX-stage operand muxes, runs a 16-iteration shift-add or shift-subtract sequence, and holds the EX stage with `stall_X` until the result is ready. It then keeps the result stable until the pipeline advances (`flow`), so a stalled downstream stage cannot re-trigger the same instruction.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; iteration count equals `WIDTH`.

Ports:
- `clk`  input  1  pipeline clock, rising-edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `aluop`  input  lc3b_aluop  EX-stage ALU opcode; only `alu_mult` and `alu_div` start the engine.
- `sr1`  input  WIDTH  operand A (multiplicand / dividend), already forwarded.
- `sr2`  input  WIDTH  operand B (multiplier / divisor), already forwarded.
- `flow`  input  1  pipeline advancing out of EX this cycle.
- `solution`  output  WIDTH  registered result.
- `stall_X`  output  1  hold the EX stage and everything upstream.
- `done`  output  1  `solution` valid for the instruction currently in EX.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if `aluop` is mult or div:
  - latch `|sr1|`, `|sr2|`, the result sign (`sr1[15]^sr2[15]`), op type and a divide-by-zero flag (`sr2==0`);
  - clear the accumulator, set the iteration counter to 0, go to RUN.
  - Any other `aluop` keeps the FSM in IDLE.
- RUN: one iteration per cycle; the counter increments each cycle. When the counter reaches `WIDTH-1`, the final iteration completes, `solution` is written and the FSM goes to DONE.
  - Multiply: shift-add on magnitudes. Result is the low `WIDTH` bits of the signed product. The high half is discarded.
  - Divide: restoring division on magnitudes gives quotient Q. The remainder is discarded.
- Sign fixup on the write: if the sign flag is set, `solution = -magnitude` (two's complement, wraps).
  - `-32768 * 1 = 0x8000`.
  - `0x8000 / 0xFFFF = 0x8000` (overflow wraps; no exception).
- Divide by zero: `solution = 0xFFFF`, regardless of operand signs. It still takes the full 16 iterations, so latency is fixed.
- DONE: `done=1`, `stall_X=0`, `solution` held.
  - `flow=1`: go to IDLE. The next instruction is evaluated the following cycle.
  - `flow=0`: stay in DONE indefinitely, with `solution` unchanged.
- `stall_X = (IDLE && aluop∈{mult,div}) || RUN`. This is combinational so the start cycle is stalled.
- In RUN, changes on `aluop`, `sr1`, `sr2` and `flow` are ignored; operands are latched.
- Outputs in IDLE: `done=0`, and `solution` keeps its last value.

## Timing
- Reset (async assert, any state): IDLE, `solution=0`, `done=0`, counter 0, `stall_X=0` unless a mult/div is on `aluop`.
- A reset asserted mid-RUN aborts the operation. No partial result is written.
- Start at edge N (op present in cycle N-1 while in IDLE). RUN covers cycles N..N+15. DONE is entered at edge N+16.
- `stall_X` is high for 17 consecutive cycles: the start cycle plus 16 RUN cycles. It falls in the first DONE cycle.
- `solution`/`done` are valid from edge N+16.
- Back-to-back ops: with DONE and `flow=1` at edge M, the next mult/div starts at edge M+1. The minimum op-to-op spacing is 18 cycles.
- No combinational path from `sr1`/`sr2` to any output.

## Test plan
- Multiply 3 × 5 → `stall_X` high exactly 17 cycles, then `solution=0x000F`, `done=1`. `flow=1` returns the FSM to IDLE.
- Signed/truncated multiply: `0xFFF9 × 0x0003` → `0xFFEB`; `0x0100 × 0x0100` → `0x0000`.
- Divide: `100/7` → `0x000E`; `0xFF9C/0x0007` → `0xFFF2`; `0x8000/0xFFFF` → `0x8000`.
- Divide by zero: `0x1234/0` and `0xFFFF/0` → `0xFFFF`, each after a 17-cycle stall.
- Hold in DONE: `flow=0` for 5 cycles while `sr1`/`sr2` toggle → `solution` stable, `stall_X=0`, no restart. `flow=1` → IDLE.
- Reset pulse at RUN iteration 8 → immediate IDLE, `solution=0`, `done=0`. A following `7 × 6` runs a clean 17-cycle stall → `0x002A`. A non-mult/div `aluop` (e.g. add) never asserts `stall_X`.
